pc_sequencer: RTL

Fetch controller that sequences the program counter register (`PC_Module`) and the instruction-memory port. It drives `PC_Next` every cycle and issues one instruction-fetch request at a time over a valid/ready handshake. It holds the fetched instruction for decode and applies branch and trap redirects, with trap taking priority. It sits between `PC_Module`, instruction memory and the decode stage.

---
 rtl/pc_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch controller. Drives PC_Next to the PC register every cycle
//               and issues one instruction fetch at a time over a valid/ready
//               handshake. It holds the fetched word for decode and applies
//               branch and trap redirects, with trap taking priority.
//               Optional feature macro: PC_SEQ_MISALIGN_TRAP_EN
//                 defined   - a misaligned taken branch traps and pulses
//                             misalign_fault
//                 undefined - branch_target[1:0] forced to 0, fault tied low
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic [31:0] PC_Next,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        trap,
    output logic        misalign_fault
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_kill;
    logic        r_instr_valid;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;

    logic        w_redirect;
    logic        w_req_fire;
    logic [31:0] w_target;

    // Redirects are only honoured once the boot cycle has passed
    assign w_redirect = (r_state != ST_BOOT) && (trap || branch_taken);

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misalign_fault;

    // A taken branch to a non word-aligned address is turned into a trap
    assign w_misaligned = branch_taken && !trap && (branch_target[1:0] != 2'b00);
    assign w_target     = (trap || w_misaligned) ? TRAP_VECTOR : branch_target;

    // One-cycle fault pulse following a misaligned redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign_fault <= 1'b0;
        end else begin
            r_misalign_fault <= w_redirect && w_misaligned;
        end
    end

    assign misalign_fault = r_misalign_fault;
`else
    logic w_unused_target_bits;

    // Low target bits are dropped so fetches always stay word aligned
    assign w_target             = trap ? TRAP_VECTOR : {branch_target[31:2], 2'b00};
    assign w_unused_target_bits = &{1'b0, branch_target[1:0]};
    assign misalign_fault       = 1'b0;
`endif

    // A request is only offered while idle in REQ and not being redirected
    assign imem_req_valid = (r_state == ST_REQ) && !w_redirect;
    assign imem_req_addr  = PC;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Next PC: boot vector, then redirect target, then sequential advance
    always_comb begin
        PC_Next = PC;
        if (r_state == ST_BOOT) begin
            PC_Next = RESET_VECTOR;
        end else if (w_redirect) begin
            PC_Next = w_target;
        end else if (w_req_fire) begin
            PC_Next = PC + 32'd4;
        end
    end

    // Fetch sequencing state machine with registered decode-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_BOOT;
            r_kill        <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= 32'd0;
            r_instr_pc    <= 32'd0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (w_req_fire) begin
                        r_instr_pc <= PC;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_kill <= 1'b0;
                        if (r_kill || w_redirect) begin
                            // Response belongs to an abandoned path
                            r_state <= ST_REQ;
                        end else begin
                            r_instr       <= imem_rsp_data;
                            r_instr_valid <= 1'b1;
                            r_state       <= ST_HOLD;
                        end
                    end else if (w_redirect) begin
                        // Response still in flight; discard it on arrival
                        r_kill <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // A redirect wins over a same-cycle decode accept
                    if (w_redirect || instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule
`default_nettype wire
